// File: rtl/delay_exec_scoreboard_if.sv
// Decode-to-issue bundle for the dual-issue scoreboard: two decoded slots in, issue
// decisions and delayed-exec operand tags out, plus the flush/freeze controls.
interface delay_exec_scoreboard_if;
    logic       flush;
    logic       stall_in;

    logic       in0_valid;
    logic       in0_useA;
    logic       in0_useB;
    logic [4:0] in0_rs;
    logic [4:0] in0_rt;
    logic       in0_wen;
    logic [4:0] in0_rd;
    logic [2:0] in0_fu;

    logic       in1_valid;
    logic       in1_useA;
    logic       in1_useB;
    logic [4:0] in1_rs;
    logic [4:0] in1_rt;
    logic       in1_wen;
    logic [4:0] in1_rd;
    logic [2:0] in1_fu;

    logic       issue0;
    logic       issue1;
    logic       d0_delay_opA;
    logic       d0_delay_opB;
    logic [4:0] d0_regA;
    logic [4:0] d0_regB;
    logic [2:0] d0_fuA;
    logic [2:0] d0_fuB;
    logic       d1_delay_opA;
    logic       d1_delay_opB;
    logic [4:0] d1_regA;
    logic [4:0] d1_regB;
    logic [2:0] d1_fuA;
    logic [2:0] d1_fuB;
    logic       sb_stall;

    modport master (
        output flush, stall_in,
        output in0_valid, in0_useA, in0_useB, in0_rs, in0_rt, in0_wen, in0_rd, in0_fu,
        output in1_valid, in1_useA, in1_useB, in1_rs, in1_rt, in1_wen, in1_rd, in1_fu,
        input  issue0, issue1, sb_stall,
        input  d0_delay_opA, d0_delay_opB, d0_regA, d0_regB, d0_fuA, d0_fuB,
        input  d1_delay_opA, d1_delay_opB, d1_regA, d1_regB, d1_fuA, d1_fuB
    );

    modport slave (
        input  flush, stall_in,
        input  in0_valid, in0_useA, in0_useB, in0_rs, in0_rt, in0_wen, in0_rd, in0_fu,
        input  in1_valid, in1_useA, in1_useB, in1_rs, in1_rt, in1_wen, in1_rd, in1_fu,
        output issue0, issue1, sb_stall,
        output d0_delay_opA, d0_delay_opB, d0_regA, d0_regB, d0_fuA, d0_fuB,
        output d1_delay_opA, d1_delay_opB, d1_regA, d1_regB, d1_fuA, d1_fuB
    );
endinterface

// File: rtl/delay_exec_scoreboard.sv
// Issue-stage register scoreboard for the dual-issue pipe; decides issue/stall/delayed-exec per slot.
// Build option DELAY_EXEC_EN: when defined, a source one cycle from ready issues into the delayed ALU.
module delay_exec_scoreboard #(
    parameter int NREG     = 32,
    parameter int LAT_ALU  = 1,
    parameter int LAT_BRU  = 1,
    parameter int LAT_MMU  = 2,
    parameter int LAT_HILO = 3
) (
    input logic                    clk,
    input logic                    reset,
    delay_exec_scoreboard_if.slave bus
);

    typedef enum logic [2:0] {
        FU_ALU1 = 3'd0,
        FU_ALU2 = 3'd1,
        FU_BRU  = 3'd2,
        FU_MMU  = 3'd3,
        FU_HILO = 3'd4
    } fu_t;

    typedef struct packed {
        logic       hazard;
        logic       delay;
        logic [4:0] r;
        logic [2:0] fu;
    } src_t;

`ifdef DELAY_EXEC_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif

    logic [NREG-1:0] pending_q, pending_d;
    logic [2:0]      fu_q  [NREG];
    logic [2:0]      fu_d  [NREG];
    logic [1:0]      age_q [NREG];
    logic [1:0]      age_d [NREG];

    src_t s0A, s0B, s1A, s1B;
    logic hazard0, hazard1, intra;
    logic issue0, issue1;

    function automatic logic [1:0] latOf(input logic [2:0] f);
        case (fu_t'(f))
            FU_ALU1, FU_ALU2: latOf = 2'(LAT_ALU);
            FU_BRU:           latOf = 2'(LAT_BRU);
            FU_MMU:           latOf = 2'(LAT_MMU);
            FU_HILO:          latOf = 2'(LAT_HILO);
            default:          latOf = 2'(LAT_ALU);
        endcase
    endfunction

    // An entry one cycle from ready can be consumed straight off exec_result; older ones must wait.
    function automatic src_t checkSrc(input logic used, input logic [4:0] r,
                                      input logic pend, input logic [1:0] age,
                                      input logic [2:0] f);
        src_t s;
        logic live;
        live     = used && (r != 5'd0) && pend;
        s.delay  = live && (age == 2'd1) && DELAY_EN;
        s.hazard = live && !s.delay;
        s.r      = s.delay ? r : 5'd0;
        s.fu     = s.delay ? f : 3'd0;
        return s;
    endfunction

    always_comb begin
        s0A = checkSrc(bus.in0_useA, bus.in0_rs, pending_q[bus.in0_rs], age_q[bus.in0_rs], fu_q[bus.in0_rs]);
        s0B = checkSrc(bus.in0_useB, bus.in0_rt, pending_q[bus.in0_rt], age_q[bus.in0_rt], fu_q[bus.in0_rt]);
        s1A = checkSrc(bus.in1_useA, bus.in1_rs, pending_q[bus.in1_rs], age_q[bus.in1_rs], fu_q[bus.in1_rs]);
        s1B = checkSrc(bus.in1_useB, bus.in1_rt, pending_q[bus.in1_rt], age_q[bus.in1_rt], fu_q[bus.in1_rt]);

        hazard0 = s0A.hazard || s0B.hazard;
        hazard1 = s1A.hazard || s1B.hazard;
        intra   = bus.in0_wen && (bus.in0_rd != 5'd0) &&
                  ((bus.in1_useA && (bus.in1_rs == bus.in0_rd)) ||
                   (bus.in1_useB && (bus.in1_rt == bus.in0_rd)));

        issue0 = !reset && bus.in0_valid && !hazard0 && !bus.stall_in && !bus.flush;
        issue1 = issue0 && bus.in1_valid && !hazard1 && !intra;

        bus.issue0   = issue0;
        bus.issue1   = issue1;
        bus.sb_stall = !reset && bus.in0_valid && hazard0;

        bus.d0_delay_opA = issue0 && s0A.delay;
        bus.d0_delay_opB = issue0 && s0B.delay;
        bus.d0_regA      = issue0 ? s0A.r  : 5'd0;
        bus.d0_regB      = issue0 ? s0B.r  : 5'd0;
        bus.d0_fuA       = issue0 ? s0A.fu : 3'd0;
        bus.d0_fuB       = issue0 ? s0B.fu : 3'd0;

        bus.d1_delay_opA = issue1 && s1A.delay;
        bus.d1_delay_opB = issue1 && s1B.delay;
        bus.d1_regA      = issue1 ? s1A.r  : 5'd0;
        bus.d1_regB      = issue1 ? s1B.r  : 5'd0;
        bus.d1_fuA       = issue1 ? s1A.fu : 3'd0;
        bus.d1_fuB       = issue1 ? s1B.fu : 3'd0;
    end

    // Age every pending entry, then let this cycle's issued writes claim their destinations (slot 1 last).
    always_comb begin
        pending_d = pending_q;
        fu_d      = fu_q;
        age_d     = age_q;
        if (!bus.stall_in) begin
            for (int i = 0; i < NREG; i++) begin
                if (pending_q[i]) begin
                    age_d[i] = age_q[i] - 2'd1;
                    if (age_q[i] == 2'd1) begin
                        pending_d[i] = 1'b0;
                    end
                end
            end
            if (issue0 && bus.in0_wen && (bus.in0_rd != 5'd0)) begin
                pending_d[bus.in0_rd] = 1'b1;
                fu_d[bus.in0_rd]      = bus.in0_fu;
                age_d[bus.in0_rd]     = latOf(bus.in0_fu);
            end
            if (issue1 && bus.in1_wen && (bus.in1_rd != 5'd0)) begin
                pending_d[bus.in1_rd] = 1'b1;
                fu_d[bus.in1_rd]      = bus.in1_fu;
                age_d[bus.in1_rd]     = latOf(bus.in1_fu);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            pending_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                fu_q[i]  <= 3'd0;
                age_q[i] <= 2'd0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NREG; i++) begin
                fu_q[i]  <= fu_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_delay_exec_scoreboard.sv
// Self-checking bench for delay_exec_scoreboard: directed vector table, a stall sequence,
// then random traffic scored against a timestamp-based model of register readiness.
module tb_delay_exec_scoreboard;

`ifdef DELAY_EXEC_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif

    typedef struct packed {
        logic       v, uA, uB;
        logic [4:0] rs, rt;
        logic       wen;
        logic [4:0] rd;
        logic [2:0] fu;
    } slot_t;

    typedef struct packed {
        logic  rst, flush, stall;
        slot_t s0, s1;
    } ins_t;

    typedef struct packed {
        logic       dA, dB;
        logic [4:0] regA, regB;
        logic [2:0] fuA, fuB;
    } dslot_t;

    typedef struct packed {
        logic   iss0, iss1, sb;
        dslot_t d0, d1;
    } outs_t;

    typedef struct {
        string name;
        ins_t  in;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    localparam slot_t  IDLE = '0;
    localparam dslot_t NOD  = '0;

    // Model state: when each register's producer issued (in unfrozen cycles) and its latency.
    bit         mValid[32];
    int         mProd[32];
    int         mLat[32];
    logic [2:0] mFu[32];
    int         mEdges = 0;

    always #5 clk = ~clk;

    delay_exec_scoreboard_if bus ();

    delay_exec_scoreboard dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic slot_t mkSlot(input logic v, uA, uB, input logic [4:0] rs, rt,
                                     input logic wen, input logic [4:0] rd, input logic [2:0] fu);
        slot_t s;
        s.v = v; s.uA = uA; s.uB = uB; s.rs = rs; s.rt = rt; s.wen = wen; s.rd = rd; s.fu = fu;
        return s;
    endfunction

    function automatic slot_t rdA(input logic [4:0] r);
        return mkSlot(1'b1, 1'b1, 1'b0, r, 5'd0, 1'b0, 5'd0, 3'd0);
    endfunction

    function automatic slot_t rdB(input logic [4:0] r);
        return mkSlot(1'b1, 1'b0, 1'b1, 5'd0, r, 1'b0, 5'd0, 3'd0);
    endfunction

    function automatic slot_t wr(input logic [4:0] rd, input logic [2:0] fu);
        return mkSlot(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, rd, fu);
    endfunction

    function automatic ins_t mkIn(input logic rst, flush, stall, input slot_t s0, s1);
        ins_t x;
        x.rst = rst; x.flush = flush; x.stall = stall; x.s0 = s0; x.s1 = s1;
        return x;
    endfunction

    function automatic dslot_t mkD(input logic dA, dB, input logic [4:0] ra, rb,
                                   input logic [2:0] fa, fb);
        dslot_t d;
        d.dA = dA; d.dB = dB; d.regA = ra; d.regB = rb; d.fuA = fa; d.fuB = fb;
        return d;
    endfunction

    function automatic outs_t mkOut(input logic i0, i1, sb, input dslot_t d0, d1);
        outs_t o;
        o.iss0 = i0; o.iss1 = i1; o.sb = sb; o.d0 = d0; o.d1 = d1;
        return o;
    endfunction

    function automatic int latOf(input logic [2:0] f);
        case (f)
            3'd2:    return 1;
            3'd3:    return 2;
            3'd4:    return 3;
            default: return 1;
        endcase
    endfunction

    // A source is ready once more than LAT unfrozen cycles have passed since its producer issued;
    // exactly LAT cycles means the value is on exec_result right now.
    task automatic srcEval(input logic used, input logic [4:0] r,
                           output logic hz, output logic dl, output logic [2:0] f);
        int el;
        hz = 1'b0; dl = 1'b0; f = 3'd0;
        if (used && r != 5'd0 && mValid[r]) begin
            el = mEdges - mProd[r];
            if (el < mLat[r] || (el == mLat[r] && !DE)) begin
                hz = 1'b1;
            end else if (el == mLat[r]) begin
                dl = 1'b1;
                f  = mFu[r];
            end
        end
    endtask

    task automatic modelEval(input ins_t x, output outs_t o);
        logic h0A, h0B, h1A, h1B, l0A, l0B, l1A, l1B, intra;
        logic [2:0] f0A, f0B, f1A, f1B;
        o = '0;
        srcEval(x.s0.uA, x.s0.rs, h0A, l0A, f0A);
        srcEval(x.s0.uB, x.s0.rt, h0B, l0B, f0B);
        srcEval(x.s1.uA, x.s1.rs, h1A, l1A, f1A);
        srcEval(x.s1.uB, x.s1.rt, h1B, l1B, f1B);
        intra  = x.s0.wen && x.s0.rd != 5'd0 &&
                 ((x.s1.uA && x.s1.rs == x.s0.rd) || (x.s1.uB && x.s1.rt == x.s0.rd));
        o.iss0 = !x.rst && x.s0.v && !(h0A || h0B) && !x.stall && !x.flush;
        o.iss1 = o.iss0 && x.s1.v && !(h1A || h1B) && !intra;
        o.sb   = !x.rst && x.s0.v && (h0A || h0B);
        if (o.iss0) o.d0 = mkD(l0A, l0B, l0A ? x.s0.rs : 5'd0, l0B ? x.s0.rt : 5'd0, f0A, f0B);
        if (o.iss1) o.d1 = mkD(l1A, l1B, l1A ? x.s1.rs : 5'd0, l1B ? x.s1.rt : 5'd0, f1A, f1B);
    endtask

    task automatic modelStep(input ins_t x, input outs_t o);
        if (x.rst || x.flush) begin
            for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
        end else if (!x.stall) begin
            if (o.iss0 && x.s0.wen && x.s0.rd != 5'd0) begin
                mValid[x.s0.rd] = 1'b1; mProd[x.s0.rd] = mEdges;
                mLat[x.s0.rd] = latOf(x.s0.fu); mFu[x.s0.rd] = x.s0.fu;
            end
            if (o.iss1 && x.s1.wen && x.s1.rd != 5'd0) begin
                mValid[x.s1.rd] = 1'b1; mProd[x.s1.rd] = mEdges;
                mLat[x.s1.rd] = latOf(x.s1.fu); mFu[x.s1.rd] = x.s1.fu;
            end
            mEdges++;
        end
    endtask

    task automatic applyStimulus(input ins_t x);
        @(negedge clk);
        reset         = x.rst;
        bus.flush     = x.flush;
        bus.stall_in  = x.stall;
        bus.in0_valid = x.s0.v;  bus.in0_useA = x.s0.uA; bus.in0_useB = x.s0.uB;
        bus.in0_rs    = x.s0.rs; bus.in0_rt   = x.s0.rt; bus.in0_wen  = x.s0.wen;
        bus.in0_rd    = x.s0.rd; bus.in0_fu   = x.s0.fu;
        bus.in1_valid = x.s1.v;  bus.in1_useA = x.s1.uA; bus.in1_useB = x.s1.uB;
        bus.in1_rs    = x.s1.rs; bus.in1_rt   = x.s1.rt; bus.in1_wen  = x.s1.wen;
        bus.in1_rd    = x.s1.rd; bus.in1_fu   = x.s1.fu;
        #2;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act.iss0 = bus.issue0; act.iss1 = bus.issue1; act.sb = bus.sb_stall;
        act.d0 = mkD(bus.d0_delay_opA, bus.d0_delay_opB, bus.d0_regA, bus.d0_regB, bus.d0_fuA, bus.d0_fuB);
        act.d1 = mkD(bus.d1_delay_opA, bus.d1_delay_opB, bus.d1_regA, bus.d1_regB, bus.d1_fuA, bus.d1_fuB);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got iss0=%b iss1=%b sb=%b d0=%h d1=%h, expected iss0=%b iss1=%b sb=%b d0=%h d1=%h",
                     name, act.iss0, act.iss1, act.sb, act.d0, act.d1,
                     exp.iss0, exp.iss1, exp.sb, exp.d0, exp.d1);
        end
    endtask

    task automatic runVec(input string name, input ins_t x, input outs_t exp);
        applyStimulus(x);
        checkOutput(name, exp);
    endtask

    task automatic addRow(input string name, input ins_t x, input outs_t exp);
        vec_t v;
        v.name = name; v.in = x; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        outs_t ok, stallOut;
        ins_t  rx;
        outs_t rexp;
        ok       = mkOut(1'b1, 1'b0, 1'b0, NOD, NOD);
        stallOut = mkOut(1'b0, 1'b0, 1'b1, NOD, NOD);

        addRow("reset_a",       mkIn(1, 0, 0, rdA(5), IDLE), mkOut(0, 0, 0, NOD, NOD));
        addRow("reset_b",       mkIn(1, 0, 0, rdA(5), IDLE), mkOut(0, 0, 0, NOD, NOD));
        addRow("post_reset_r5", mkIn(0, 0, 0, rdA(5), IDLE), ok);
        addRow("alu_wr_r5",     mkIn(0, 0, 0, wr(5, 0), IDLE), ok);
        addRow("alu_rd_r5",     mkIn(0, 0, 0, rdA(5), IDLE),
               mkOut(DE, 0, !DE, DE ? mkD(1, 0, 5, 0, 0, 0) : NOD, NOD));
        addRow("alu_rd_r5_late", mkIn(0, 0, 0, rdA(5), IDLE), ok);
        addRow("mmu_wr_r8",     mkIn(0, 0, 0, wr(8, 3), IDLE), ok);
        addRow("mmu_hazard",    mkIn(0, 0, 0, rdB(8), IDLE), stallOut);
        addRow("mmu_delay",     mkIn(0, 0, 0, rdB(8), IDLE),
               mkOut(DE, 0, !DE, DE ? mkD(0, 1, 0, 8, 0, 3) : NOD, NOD));
        addRow("mmu_late",      mkIn(0, 0, 0, rdB(8), IDLE), ok);
        addRow("intra_split",   mkIn(0, 0, 0, wr(3, 0), rdA(3)), ok);
        addRow("intra_replay",  mkIn(0, 0, 0, rdA(3), IDLE),
               mkOut(DE, 0, !DE, DE ? mkD(1, 0, 3, 0, 0, 0) : NOD, NOD));
        addRow("intra_late",    mkIn(0, 0, 0, rdA(3), IDLE), ok);
        addRow("hilo_wr_r2",    mkIn(0, 0, 0, wr(2, 4), IDLE), ok);
        addRow("flush",         mkIn(0, 1, 0, IDLE, IDLE), mkOut(0, 0, 0, NOD, NOD));
        addRow("after_flush",   mkIn(0, 0, 0, rdA(2), IDLE), ok);
        addRow("wr_r0",         mkIn(0, 0, 0, wr(0, 3), IDLE), ok);
        addRow("rd_r0",         mkIn(0, 0, 0, mkSlot(1, 1, 1, 0, 0, 0, 0, 0), IDLE), ok);
        addRow("same_rd",       mkIn(0, 0, 0, wr(4, 3), wr(4, 0)), mkOut(1, 1, 0, NOD, NOD));
        addRow("same_rd_read",  mkIn(0, 0, 0, rdA(4), IDLE),
               mkOut(DE, 0, !DE, DE ? mkD(1, 0, 4, 0, 0, 0) : NOD, NOD));
        addRow("same_rd_late",  mkIn(0, 0, 0, rdA(4), IDLE), ok);
        addRow("slot1_wr_r6",   mkIn(0, 0, 0, wr(6, 1), IDLE), ok);
        addRow("slot1_delay",   mkIn(0, 0, 0, rdA(1), rdB(6)),
               mkOut(1, DE, 0, NOD, DE ? mkD(0, 1, 0, 6, 0, 1) : NOD));

        $display("[TB] directed vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i].name, vecs[i].in, vecs[i].exp);
        end

        $display("[TB] stall_in freeze sequence");
        runVec("frz_wr_r8", mkIn(0, 0, 0, wr(8, 3), IDLE), ok);
        for (int k = 0; k < 3; k++) begin
            runVec("frz_hold", mkIn(0, 0, 1, rdB(8), IDLE), stallOut);
        end
        runVec("frz_release_hz", mkIn(0, 0, 0, rdB(8), IDLE), stallOut);
        runVec("frz_release_dly", mkIn(0, 0, 0, rdB(8), IDLE),
               mkOut(DE, 0, !DE, DE ? mkD(0, 1, 0, 8, 0, 3) : NOD, NOD));
        runVec("frz_release_late", mkIn(0, 0, 0, rdB(8), IDLE), ok);

        $display("[TB] random traffic against reference model");
        for (int n = 0; n < 2000; n++) begin
            rx.rst   = (n == 0) || ($urandom % 80 == 0);
            rx.flush = ($urandom % 25 == 0);
            rx.stall = ($urandom % 8 == 0);
            rx.s0 = mkSlot(($urandom % 5) != 0, 1'($urandom), 1'($urandom), 5'($urandom % 8),
                           5'($urandom % 8), 1'($urandom), 5'($urandom % 8), 3'($urandom % 5));
            rx.s1 = mkSlot(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom % 8),
                           5'($urandom % 8), 1'($urandom), 5'($urandom % 8), 3'($urandom % 5));
            modelEval(rx, rexp);
            runVec("random", rx, rexp);
            modelStep(rx, rexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
